// File: rtl/tlb_refill_walker_if.sv
// Memory read port between the page-table walker (master) and the memory system (slave).
// The request transfers on a cycle where MemReq && MemReady are both high. MemReq and MemAdr
// stay stable until then. The response is a single MemRespValid beat, with MemRespErr and MemRData qualifying it.
interface tlb_refill_walker_if #(
    parameter int XLEN    = 64,
    parameter int PA_BITS = 56
);
    logic               MemReq;
    logic [PA_BITS-1:0] MemAdr;
    logic               MemReady;
    logic               MemRespValid;
    logic               MemRespErr;
    logic [XLEN-1:0]    MemRData;

    modport master (
        output MemReq,
        output MemAdr,
        input  MemReady,
        input  MemRespValid,
        input  MemRespErr,
        input  MemRData
    );

    modport slave (
        input  MemReq,
        input  MemAdr,
        output MemReady,
        output MemRespValid,
        output MemRespErr,
        output MemRData
    );
endinterface

// File: rtl/tlb_refill_walker.sv
// Sv39 hardware page-table walker: services one MMU port's TLB misses and returns a leaf PTE or a fault.
module tlb_refill_walker #(
    parameter int XLEN    = 64,
    parameter int PA_BITS = 56,
    parameter int LEVELS  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     SATP_REGW,
    input  logic [XLEN-1:0]     VAdr,
    input  logic                TLBMiss,
    input  logic                TLBFlush,
    tlb_refill_walker_if.master mem,
    output logic [XLEN-1:0]     PTE,
    output logic [1:0]          PageTypeWriteVal,
    output logic                TLBWrite,
    output logic                WalkFault,
    output logic                WalkAccessFault,
    output logic                DisableTranslation,
    output logic [2:0]          dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_LEAF, S_FAULT, S_DRAIN
    } state_t;

    localparam logic [1:0] TOP_LEVEL = 2'(LEVELS - 1);

    state_t          state_q, state_d;
    logic [1:0]      level_q, level_d;
    logic [43:0]     cur_ppn_q, cur_ppn_d;
    logic [26:0]     vpn_q, vpn_d;
    logic [XLEN-1:0] pte_q, pte_d;
    logic [1:0]      page_type_q, page_type_d;
    logic            err_q, err_d;

    logic        pte_v, pte_r, pte_w, pte_x, misaligned;
    logic [43:0] pte_ppn;
    logic [8:0]  vpn_sel;

    assign pte_v   = mem.MemRData[0];
    assign pte_r   = mem.MemRData[1];
    assign pte_w   = mem.MemRData[2];
    assign pte_x   = mem.MemRData[3];
    assign pte_ppn = mem.MemRData[53:10];

    // A superpage leaf must have the PPN bits below its page size cleared.
    assign misaligned = ((level_q == 2'd2) && (pte_ppn[17:0] != '0)) ||
                        ((level_q == 2'd1) && (pte_ppn[8:0]  != '0));

    always_comb begin
        case (level_q)
            2'd2:    vpn_sel = vpn_q[26:18];
            2'd1:    vpn_sel = vpn_q[17:9];
            default: vpn_sel = vpn_q[8:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        cur_ppn_d   = cur_ppn_q;
        vpn_d       = vpn_q;
        pte_d       = pte_q;
        page_type_d = page_type_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (TLBMiss && !TLBFlush) begin
                    state_d   = S_REQ;
                    vpn_d     = VAdr[38:12];
                    cur_ppn_d = SATP_REGW[43:0];
                    level_d   = TOP_LEVEL;
                end
            end
            S_REQ: begin
                // An accepted request always owes a response, so a flush must drain it.
                if (mem.MemReady)  state_d = TLBFlush ? S_DRAIN : S_WAIT;
                else if (TLBFlush) state_d = S_IDLE;
            end
            S_WAIT: begin
                if (mem.MemRespValid) begin
                    if (TLBFlush) begin
                        state_d = S_IDLE;
                    end else if (mem.MemRespErr) begin
                        state_d = S_FAULT;
                        err_d   = 1'b1;
                    end else if (!pte_v || (pte_w && !pte_r)) begin
                        state_d = S_FAULT;
                    end else if (pte_r || pte_x) begin
                        if (misaligned) begin
                            state_d = S_FAULT;
                        end else begin
                            state_d     = S_LEAF;
                            pte_d       = mem.MemRData;
                            page_type_d = level_q;
                        end
                    end else if (level_q == 2'd0) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d   = S_REQ;
                        cur_ppn_d = pte_ppn;
                        level_d   = level_q - 2'd1;
                    end
                end else if (TLBFlush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem.MemRespValid) state_d = S_IDLE;
            end
            S_LEAF: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            level_q     <= TOP_LEVEL;
            cur_ppn_q   <= '0;
            vpn_q       <= '0;
            pte_q       <= '0;
            page_type_q <= 2'b00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            cur_ppn_q   <= cur_ppn_d;
            vpn_q       <= vpn_d;
            pte_q       <= pte_d;
            page_type_q <= page_type_d;
            err_q       <= err_d;
        end
    end

    assign mem.MemReq         = (state_q == S_REQ);
    assign mem.MemAdr         = PA_BITS'({cur_ppn_q, vpn_sel, 3'b000});
    assign PTE                = pte_q;
    assign PageTypeWriteVal   = page_type_q;
    assign TLBWrite           = (state_q == S_LEAF) && !TLBFlush;
    assign WalkFault          = (state_q == S_FAULT) && !err_q;
    assign WalkAccessFault    = (state_q == S_FAULT) && err_q;
    assign DisableTranslation = (state_q != S_IDLE);
    assign dbg_state          = state_q;

    wire unused_bits = &{1'b0, SATP_REGW[XLEN-1:44], VAdr[XLEN-1:39], VAdr[11:0]};
endmodule

// File: tb/tb_tlb_refill_walker.sv
// Bench for tlb_refill_walker: table vectors, hand sequences for flush/stall/reset, and random walks vs a model.
module tb_tlb_refill_walker;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] SATP_REGW, VAdr;
    logic        TLBMiss, TLBFlush;
    logic [63:0] PTE;
    logic [1:0]  PageTypeWriteVal;
    logic        TLBWrite, WalkFault, WalkAccessFault, DisableTranslation;
    logic [2:0]  dbg_state;

    tlb_refill_walker_if #(.XLEN(64), .PA_BITS(56)) mif ();

    tlb_refill_walker #(.XLEN(64), .PA_BITS(56), .LEVELS(3)) dut (
        .clk(clk), .reset(reset), .SATP_REGW(SATP_REGW), .VAdr(VAdr),
        .TLBMiss(TLBMiss), .TLBFlush(TLBFlush), .mem(mif), .PTE(PTE),
        .PageTypeWriteVal(PageTypeWriteVal), .TLBWrite(TLBWrite), .WalkFault(WalkFault),
        .WalkAccessFault(WalkAccessFault), .DisableTranslation(DisableTranslation),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model and bus agent: per-request ready stalls and response delays.
    logic [63:0] mem_m [logic [55:0]];
    logic [55:0] err_addr;
    int          stall_cfg [8];
    int          delay_cfg [8];
    int          req_idx, stall_cnt, hs_count;
    logic [55:0] pend_adr_q [$];
    int          pend_dly_q [$];

    function automatic logic [63:0] mem_rd(input logic [55:0] a);
        return mem_m.exists(a) ? mem_m[a] : 64'h0;
    endfunction

    always @(negedge clk) begin
        mif.MemRespValid = 1'b0;
        mif.MemRespErr   = 1'b0;
        mif.MemRData     = '0;
        if (pend_adr_q.size() > 0) begin
            if (pend_dly_q[0] == 0) begin
                mif.MemRespValid = 1'b1;
                mif.MemRespErr   = (pend_adr_q[0] == err_addr);
                mif.MemRData     = mem_rd(pend_adr_q[0]);
                void'(pend_adr_q.pop_front());
                void'(pend_dly_q.pop_front());
            end else begin
                pend_dly_q[0] = pend_dly_q[0] - 1;
            end
        end
        mif.MemReady = 1'b0;
        if (mif.MemReq === 1'b1) begin
            if (stall_cnt < stall_cfg[req_idx % 8]) begin
                stall_cnt++;
            end else begin
                mif.MemReady = 1'b1;
                pend_adr_q.push_back(mif.MemAdr);
                pend_dly_q.push_back(delay_cfg[req_idx % 8]);
                req_idx++;
                hs_count++;
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    task automatic clear_cfg();
        for (int i = 0; i < 8; i++) begin
            stall_cfg[i] = 0;
            delay_cfg[i] = 0;
        end
    endtask

    function automatic logic [55:0] pte_addr(input logic [43:0] ppn, input logic [63:0] va, input int lvl);
        logic [63:0] vpn;
        logic [63:0] a;
        vpn = (va >> (12 + 9 * lvl)) & 64'h1FF;
        a   = {20'h0, ppn} * 64'd4096 + vpn * 64'd8;
        return a[55:0];
    endfunction

    // Lays a walk's PTEs (p0 = level 2) into memory along the path they themselves describe.
    task automatic place(input logic [63:0] satp, input logic [63:0] va,
                         input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2,
                         input int err_lvl);
        logic [63:0] p [3];
        logic [43:0] ppn;
        logic [55:0] a;
        p[0] = p0; p[1] = p1; p[2] = p2;
        mem_m.delete();
        err_addr = '1;
        ppn = satp[43:0];
        for (int lvl = 2; lvl >= 0; lvl--) begin
            a = pte_addr(ppn, va, lvl);
            if (lvl == err_lvl) err_addr = a;
            mem_m[a] = p[2 - lvl];
            if (!p[2 - lvl][0] || p[2 - lvl][1] || p[2 - lvl][3]) break;
            ppn = p[2 - lvl][53:10];
        end
    endtask

    // Reference walk: kind 1 = TLB write, 2 = page fault, 3 = access fault.
    typedef struct {
        int          kind;
        int          n_acc;
        logic [63:0] pte;
        logic [1:0]  pt;
    } ref_t;

    function automatic ref_t ref_walk(input logic [63:0] satp, input logic [63:0] va);
        ref_t        r;
        logic [43:0] ppn;
        logic [55:0] a;
        logic [63:0] e;
        r = '{kind: 2, n_acc: 0, pte: 64'h0, pt: 2'b00};
        ppn = satp[43:0];
        for (int lvl = 2; lvl >= 0; lvl--) begin
            a = pte_addr(ppn, va, lvl);
            r.n_acc++;
            if (a == err_addr) begin r.kind = 3; return r; end
            e = mem_rd(a);
            if (!e[0] || (e[2] && !e[1])) return r;
            if (e[1] || e[3]) begin
                if ((64'(e[53:10]) % (64'd1 << (9 * lvl))) != 0) return r;
                r.kind = 1; r.pte = e; r.pt = 2'(lvl);
                return r;
            end
            ppn = e[53:10];
        end
        return r;
    endfunction

    int          res_kind, res_cyc, res_pulses, res_idle, res_unstable;
    logic [63:0] res_pte;
    logic [1:0]  res_pt;

    // Cycle 0 is the cycle in which TLBMiss is sampled; results are observed in later cycles.
    task automatic run_walk(input logic [63:0] satp, input logic [63:0] va, input int flush_at);
        int          cyc;
        bit          done, prev_stall;
        logic [55:0] prev_adr;
        res_kind = 0; res_cyc = -1; res_pulses = 0; res_idle = -1; res_unstable = 0;
        res_pte = '0; res_pt = '0;
        hs_count = 0; req_idx = 0;
        done = 0; prev_stall = 0; prev_adr = '0; cyc = 0;
        @(negedge clk); #1;
        SATP_REGW = satp; VAdr = va; TLBMiss = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk); #1;
            cyc++;
            if (TLBWrite)        begin res_pulses++; res_kind = 1; res_cyc = cyc; res_pte = PTE; res_pt = PageTypeWriteVal; end
            if (WalkFault)       begin res_pulses++; res_kind = 2; res_cyc = cyc; end
            if (WalkAccessFault) begin res_pulses++; res_kind = 3; res_cyc = cyc; end
            if (flush_at < 0 && prev_stall && (!mif.MemReq || mif.MemAdr != prev_adr)) res_unstable++;
            prev_stall = mif.MemReq && !mif.MemReady;
            prev_adr   = mif.MemAdr;
            if (!DisableTranslation) begin res_idle = cyc; done = 1; end
            TLBMiss  = 1'b0;
            TLBFlush = (cyc == flush_at);
        end
        TLBFlush = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL walk_timeout: got busy after 300 cycles expected return to idle");
        end
    endtask

    typedef struct {
        logic [63:0] satp, vadr, p0, p1, p2;
        int          err_lvl, kind, cyc, n_acc;
        logic [63:0] pte;
        logic [1:0]  pt;
    } vec_t;
    vec_t vecs [11];

    task automatic check_walk(input string tag, input int kind, input int cyc, input int n_acc,
                              input logic [63:0] pte, input logic [1:0] pt);
        chk({tag, "_kind"},   64'(res_kind), 64'(kind));
        chk({tag, "_cycle"},  64'(res_cyc), 64'(cyc));
        chk({tag, "_pulses"}, 64'(res_pulses), 64'd1);
        chk({tag, "_idle"},   64'(res_idle), 64'(cyc + 1));
        chk({tag, "_hs"},     64'(hs_count), 64'(n_acc));
        chk({tag, "_stable"}, 64'(res_unstable), 64'd0);
        if (kind == 1) begin
            chk({tag, "_pte"}, res_pte, pte);
            chk({tag, "_pt"},  64'(res_pt), 64'(pt));
        end
    endtask

    function automatic logic [63:0] gen_pte(input int lvl);
        logic [63:0] r;
        logic [43:0] ppn, mask;
        int          c;
        logic [3:0]  perms [5];
        perms[0] = 4'b0011; perms[1] = 4'b0111; perms[2] = 4'b1001;
        perms[3] = 4'b1011; perms[4] = 4'b1111;
        r    = {$urandom, $urandom};
        ppn  = r[53:10];
        mask = (44'd1 << (9 * lvl)) - 44'd1;
        c    = $urandom_range(0, 9);
        if (c == 5 || c == 6) ppn = ppn & ~mask;
        r[53:10] = ppn;
        if (c < 5)       r[3:0] = 4'b0001;
        else if (c < 8)  r[3:0] = perms[$urandom_range(0, 4)];
        else if (c == 8) r[0]   = 1'b0;
        else             r[3:0] = 4'b0101;
        return r;
    endfunction

    initial begin
        logic [63:0] satp, va, p0, p1, p2;
        int          err_lvl, exp_cyc, stale;
        ref_t        m;

        reset = 1'b0; TLBMiss = 1'b0; TLBFlush = 1'b0; SATP_REGW = '0; VAdr = '0;
        req_idx = 0; stall_cnt = 0; hs_count = 0; err_addr = '1;
        clear_cfg();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_memreq", 64'(mif.MemReq), 64'd0);
        chk("rst_memadr", 64'(mif.MemAdr), 64'd0);
        chk("rst_tlbwrite", 64'(TLBWrite), 64'd0);
        chk("rst_walkfault", 64'(WalkFault), 64'd0);
        chk("rst_accfault", 64'(WalkAccessFault), 64'd0);
        chk("rst_distrans", 64'(DisableTranslation), 64'd0);
        chk("rst_pte", PTE, 64'd0);
        chk("rst_pagetype", 64'(PageTypeWriteVal), 64'd0);
        reset = 1'b1;

        vecs[0]  = '{64'h80000, 64'h40203ABC, 64'h20000401, 64'h20000801, 64'h20000C0F, -1, 1, 7, 3, 64'h20000C0F, 2'b00};
        vecs[1]  = '{64'h80000, 64'h40203ABC, 64'h2000000F, 64'h0, 64'h0, -1, 1, 3, 1, 64'h2000000F, 2'b10};
        vecs[2]  = '{64'h80000, 64'h40203ABC, 64'h2000040F, 64'h0, 64'h0, -1, 2, 3, 1, 64'h0, 2'b00};
        vecs[3]  = '{64'h80000, 64'h40203ABC, 64'h5, 64'h0, 64'h0, -1, 2, 3, 1, 64'h0, 2'b00};
        vecs[4]  = '{64'h80000, 64'h40203ABC, 64'h0, 64'h0, 64'h0, -1, 2, 3, 1, 64'h0, 2'b00};
        vecs[5]  = '{64'h80000, 64'h40203ABC, 64'h20000401, 64'h20000801, 64'h20000801, -1, 2, 7, 3, 64'h0, 2'b00};
        vecs[6]  = '{64'h80000, 64'h40203ABC, 64'h20000401, 64'h0, 64'h0, 1, 3, 5, 2, 64'h0, 2'b00};
        vecs[7]  = '{64'h80000, 64'h40203ABC, 64'h20000401, 64'h2008000F, 64'h0, -1, 1, 5, 2, 64'h2008000F, 2'b01};
        vecs[8]  = '{64'h80000, 64'h40203ABC, 64'h20000401, 64'h2000080F, 64'h0, -1, 2, 5, 2, 64'h0, 2'b00};
        vecs[9]  = '{64'h80000, 64'h40203ABC, 64'h20000401, 64'h20000801, 64'h20000C09, -1, 1, 7, 3, 64'h20000C09, 2'b00};
        vecs[10] = '{64'h12345, 64'h7FFFFFFFFF, 64'h1000000F, 64'h0, 64'h0, -1, 1, 3, 1, 64'h1000000F, 2'b10};

        for (int i = 0; i < 11; i++) begin
            clear_cfg();
            place(vecs[i].satp, vecs[i].vadr, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].err_lvl);
            run_walk(vecs[i].satp, vecs[i].vadr, -1);
            check_walk($sformatf("vec%0d", i), vecs[i].kind, vecs[i].cyc, vecs[i].n_acc,
                       vecs[i].pte, vecs[i].pt);
        end

        // Ready held low for 4 cycles on the first request.
        clear_cfg();
        stall_cfg[0] = 4;
        place(vecs[0].satp, vecs[0].vadr, vecs[0].p0, vecs[0].p1, vecs[0].p2, -1);
        run_walk(vecs[0].satp, vecs[0].vadr, -1);
        check_walk("stall4", 1, 11, 3, 64'h20000C0F, 2'b00);

        // Flush in the first WAIT cycle, response three cycles later.
        clear_cfg();
        delay_cfg[0] = 3;
        run_walk(vecs[0].satp, vecs[0].vadr, 2);
        chk("flush_wait_pulses", 64'(res_pulses), 64'd0);
        chk("flush_wait_idle", 64'(res_idle), 64'd6);
        chk("flush_wait_hs", 64'(hs_count), 64'd1);

        // Flush while the request is still unaccepted.
        clear_cfg();
        stall_cfg[0] = 5;
        run_walk(vecs[0].satp, vecs[0].vadr, 1);
        chk("flush_req_pulses", 64'(res_pulses), 64'd0);
        chk("flush_req_idle", 64'(res_idle), 64'd2);
        chk("flush_req_hs", 64'(hs_count), 64'd0);

        // Reset in the level-1 WAIT with the response still in flight.
        clear_cfg();
        delay_cfg[1] = 2;
        req_idx = 0; hs_count = 0;
        @(negedge clk); #1;
        SATP_REGW = vecs[0].satp; VAdr = vecs[0].vadr; TLBMiss = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            TLBMiss = 1'b0;
        end
        chk("midrst_busy", 64'(DisableTranslation), 64'd1);
        chk("midrst_hs", 64'(hs_count), 64'd2);
        reset = 1'b0;
        #1;
        chk("midrst_memreq", 64'(mif.MemReq), 64'd0);
        chk("midrst_memadr", 64'(mif.MemAdr), 64'd0);
        chk("midrst_tlbwrite", 64'(TLBWrite), 64'd0);
        chk("midrst_faults", 64'({WalkFault, WalkAccessFault}), 64'd0);
        chk("midrst_distrans", 64'(DisableTranslation), 64'd0);
        chk("midrst_pte", PTE, 64'd0);
        chk("midrst_pagetype", 64'(PageTypeWriteVal), 64'd0);
        @(negedge clk); #1;
        reset = 1'b1;
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (DisableTranslation || TLBWrite || WalkFault || WalkAccessFault) stale++;
        end
        chk("stale_resp_ignored", 64'(stale), 64'd0);
        clear_cfg();
        run_walk(vecs[0].satp, vecs[0].vadr, -1);
        check_walk("post_rst", 1, 7, 3, 64'h20000C0F, 2'b00);

        // Random walks against the reference model.
        for (int t = 0; t < 40; t++) begin
            satp = {$urandom, $urandom};
            va   = {$urandom, $urandom};
            p0 = gen_pte(2); p1 = gen_pte(1); p2 = gen_pte(0);
            err_lvl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
            clear_cfg();
            for (int i = 0; i < 3; i++) begin
                stall_cfg[i] = $urandom_range(0, 2);
                delay_cfg[i] = $urandom_range(0, 2);
            end
            place(satp, va, p0, p1, p2, err_lvl);
            m = ref_walk(satp, va);
            exp_cyc = 1;
            for (int i = 0; i < m.n_acc; i++) exp_cyc += 2 + stall_cfg[i] + delay_cfg[i];
            run_walk(satp, va, -1);
            check_walk($sformatf("rnd%0d", t), m.kind, exp_cyc, m.n_acc, m.pte, m.pt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
